// File: rtl/pixeltyper_pkg.sv
// ---------------------------------------------------------------------------
// pixeltyper_pkg
// Shared definitions for the pixeltyper letter spawning path.
//   - spawn_state_t : spawner FSM states (IDLE, WAIT, DRAW, HOLD)
//   - LETTER_COUNT  : number of legal letters (A..Z)
//   - LETTER_W      : width of a letter index
//   - COLUMN_W      : width of a screen column index
//   - spawn_entry_t : one queued spawn {letter, column}
//   - decode_draw   : splits a raw random byte into letter/column fields
// ---------------------------------------------------------------------------
package pixeltyper_pkg;

    localparam int LETTER_COUNT = 26;
    localparam int LETTER_W     = 5;
    localparam int COLUMN_W     = 3;
    localparam int ENTRY_W      = LETTER_W + COLUMN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DRAW = 2'd2,
        HOLD = 2'd3
    } spawn_state_t;

    typedef struct packed {
        logic [LETTER_W-1:0] letter;
        logic [COLUMN_W-1:0] column;
    } spawn_entry_t;

    // Low bits pick the letter, the bits just above pick the column.
    function automatic spawn_entry_t decode_draw(input logic [ENTRY_W-1:0] rnd);
        spawn_entry_t e;
        e.letter = rnd[LETTER_W-1:0];
        e.column = rnd[LETTER_W +: COLUMN_W];
        return e;
    endfunction

    function automatic logic letter_in_range(input logic [LETTER_W-1:0] letter);
        return letter < LETTER_W'(LETTER_COUNT);
    endfunction

endpackage

// File: rtl/spawn_fifo.sv
// ---------------------------------------------------------------------------
// spawn_fifo
// Small first-in first-out queue of spawn entries.
//   clk       : clock
//   resetn    : asynchronous active-low reset, empties the queue
//   push_i    : write wr_data_i (ignored when full unless a pop happens too)
//   wr_data_i : entry to write
//   pop_i     : remove the head entry (ignored when empty)
//   rd_data_o : head entry, combinational from storage
//   full_o    : count_o == DEPTH
//   empty_o   : count_o == 0
//   count_o   : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module spawn_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_fire;
    logic          pop_fire;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A push into a full queue is still legal when the head leaves in the
    // same cycle: the write lands in the slot being vacated.
    assign pop_fire  = pop_i && !empty_o;
    assign push_fire = push_i && (!full_o || pop_fire);

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_fire) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: slots are only read while count_q says they
    // hold valid data.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/letter_spawner.sv
// ---------------------------------------------------------------------------
// letter_spawner
// Periodically draws a random letter/column pair, filters out illegal and
// repeated letters, and queues accepted spawns for the game logic.
//   clk          : clock
//   resetn       : asynchronous active-low reset
//   enable       : 1 = keep drawing; 0 = stop drawing, queue still drains
//   randomnumber : per-cycle random byte, [4:0] letter, [7:5] column
//   spawn_ready  : downstream accepts the head entry this cycle
//   spawn_valid  : queue head is valid
//   spawn_letter : head letter 0..25 (0 when queue empty)
//   spawn_column : head column 0..7 (0 when queue empty)
//   pending      : queue occupancy 0..DEPTH
//   reject_count : saturating count of rejected draws
// ---------------------------------------------------------------------------
module letter_spawner
    import pixeltyper_pkg::*;
#(
    parameter int PERIOD = 50,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [7:0]             randomnumber,
    input  logic                   spawn_ready,
    output logic                   spawn_valid,
    output logic [LETTER_W-1:0]    spawn_letter,
    output logic [COLUMN_W-1:0]    spawn_column,
    output logic [$clog2(DEPTH):0] pending,
    output logic [7:0]             reject_count
);

    localparam int TIMER_W = $clog2(PERIOD);
    // WAIT covers timer values PERIOD-1 down to 0, i.e. exactly PERIOD cycles.
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(PERIOD - 1);

    spawn_state_t        state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    spawn_entry_t        cand_q, cand_d;
    logic [LETTER_W-1:0] last_letter_q, last_letter_d;
    logic                last_valid_q, last_valid_d;
    logic [7:0]          reject_q, reject_d;

    spawn_entry_t        draw;
    logic                draw_bad;
    logic                push;
    spawn_entry_t        push_data;
    spawn_entry_t        head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_fire;
    logic                push_possible;

    spawn_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push_i    (push),
        .wr_data_i (push_data),
        .pop_i     (spawn_ready),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (pending)
    );

    assign spawn_valid   = !fifo_empty;
    assign spawn_letter  = spawn_valid ? head.letter : '0;
    assign spawn_column  = spawn_valid ? head.column : '0;
    assign reject_count  = reject_q;

    assign pop_fire      = spawn_valid && spawn_ready;
    assign push_possible = !fifo_full || pop_fire;

    assign draw     = decode_draw(randomnumber);
    assign draw_bad = !letter_in_range(draw.letter) ||
                      (last_valid_q && (draw.letter == last_letter_q));

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cand_d        = cand_q;
        last_letter_d = last_letter_q;
        last_valid_d  = last_valid_q;
        reject_d      = reject_q;
        push          = 1'b0;
        push_data     = draw;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WAIT;
                    timer_d = TIMER_LOAD;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = DRAW;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            DRAW: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (draw_bad) begin
                    if (reject_q != 8'hFF) begin
                        reject_d = reject_q + 8'd1;
                    end
                end else begin
                    last_letter_d = draw.letter;
                    last_valid_d  = 1'b1;
                    if (push_possible) begin
                        push    = 1'b1;
                        state_d = WAIT;
                        timer_d = TIMER_LOAD;
                    end else begin
                        cand_d  = draw;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Dropping enable abandons the candidate; it is simply never pushed.
                if (!enable) begin
                    state_d = IDLE;
                end else if (push_possible) begin
                    push      = 1'b1;
                    push_data = cand_q;
                    state_d   = WAIT;
                    timer_d   = TIMER_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            cand_q        <= '0;
            last_letter_q <= '0;
            last_valid_q  <= 1'b0;
            reject_q      <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cand_q        <= cand_d;
            last_letter_q <= last_letter_d;
            last_valid_q  <= last_valid_d;
            reject_q      <= reject_d;
        end
    end

endmodule

// File: tb/tb_letter_spawner.sv
// ---------------------------------------------------------------------------
// tb_letter_spawner
// Drives letter_spawner with directed and random stimulus and compares every
// cycle against a queue-based behavioural model of the spawner.
// ---------------------------------------------------------------------------
module tb_letter_spawner;

    localparam int PERIOD = 4;
    localparam int DEPTH  = 4;

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic                   enable = 1'b0;
    logic [7:0]             randomnumber = '0;
    logic                   spawn_ready = 1'b0;
    logic                   spawn_valid;
    logic [4:0]             spawn_letter;
    logic [2:0]             spawn_column;
    logic [$clog2(DEPTH):0] pending;
    logic [7:0]             reject_count;

    letter_spawner #(
        .PERIOD (PERIOD),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .randomnumber (randomnumber),
        .spawn_ready  (spawn_ready),
        .spawn_valid  (spawn_valid),
        .spawn_letter (spawn_letter),
        .spawn_column (spawn_column),
        .pending      (pending),
        .reject_count (reject_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0] letter;
        logic [2:0] column;
    } ent_t;

    ent_t mq[$];
    bit   m_active;     // spawning session in progress
    bit   m_hold;       // accepted letter waiting for queue space
    int   m_wait;       // idle cycles still to go before drawing
    ent_t m_cand;
    bit   m_last_v;
    int   m_last;
    int   m_rej;
    int   cyc;
    int   rises[$];
    bit   prev_valid;

    function automatic bit model_drawing();
        return m_active && !m_hold && (m_wait == 0);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_hold   = 0;
        m_wait   = 0;
        m_last_v = 0;
        m_last   = 0;
        m_rej    = 0;
    endtask

    task automatic model_step(input bit en, input logic [7:0] rnd, input bit rdy);
        bit   pop;
        bit   push_ok;
        ent_t d;
        pop     = (mq.size() > 0) && rdy;
        push_ok = (mq.size() < DEPTH) || pop;
        d.letter = rnd[4:0];
        d.column = rnd[7:5];
        if (pop) void'(mq.pop_front());
        if (!en) begin
            m_active = 0;
            m_hold   = 0;
        end else if (!m_active) begin
            m_active = 1;
            m_wait   = PERIOD;
        end else if (m_hold) begin
            if (push_ok) begin
                mq.push_back(m_cand);
                m_hold = 0;
                m_wait = PERIOD;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (d.letter > 25 || (m_last_v && d.letter == m_last)) begin
            if (m_rej < 255) m_rej++;
        end else begin
            m_last_v = 1;
            m_last   = d.letter;
            if (push_ok) begin
                mq.push_back(d);
                m_wait = PERIOD;
            end else begin
                m_cand = d;
                m_hold = 1;
            end
        end
    endtask

    // One clock cycle: compare outputs, apply inputs, advance the model.
    task automatic cycle(input bit en, input logic [7:0] rnd, input bit rdy);
        bit exp_v;
        @(negedge clk);
        exp_v = (mq.size() != 0);
        check_eq("valid", spawn_valid, exp_v);
        check_eq("letter", spawn_letter, exp_v ? mq[0].letter : 5'd0);
        check_eq("column", spawn_column, exp_v ? mq[0].column : 3'd0);
        check_eq("pending", pending, mq.size());
        check_eq("rejects", reject_count, m_rej);
        if (spawn_valid && !prev_valid) rises.push_back(cyc);
        prev_valid = spawn_valid;
        if (spawn_valid && rdy)
            $display("cycle %0d pop letter=%0d column=%0d pending=%0d", cyc, spawn_letter, spawn_column, pending);
        enable       = en;
        randomnumber = rnd;
        spawn_ready  = rdy;
        model_step(en, rnd, rdy);
        @(posedge clk);
        cyc++;
    endtask

    // Random byte that the model would accept as a draw right now.
    function automatic logic [7:0] pick_ok();
        int l;
        l = $urandom_range(0, 25);
        while (m_last_v && l == m_last) l = $urandom_range(0, 25);
        return {3'($urandom_range(0, 7)), 5'(l)};
    endfunction

    task automatic run_to_draw(input string tag, input bit rdy);
        int n = 0;
        while (!model_drawing() && n < 20 * PERIOD + 20) begin
            cycle(1'b1, 8'($urandom), rdy);
            n++;
        end
        check_eq(tag, model_drawing(), 1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        enable      = 1'b0;
        spawn_ready = 1'b0;
        resetn      = 1'b0;
        #1;
        check_eq({tag, "_valid"}, spawn_valid, 0);
        check_eq({tag, "_letter"}, spawn_letter, 0);
        check_eq({tag, "_column"}, spawn_column, 0);
        check_eq({tag, "_pending"}, pending, 0);
        check_eq({tag, "_rejects"}, reject_count, 0);
        model_reset();
        @(negedge clk);
        #2;
        resetn = 1'b1;
        prev_valid = 0;
    endtask

    initial begin
        int n;
        model_reset();
        cyc = 0;
        prev_valid = 0;

        // Power-on reset
        do_reset("por");

        // Two illegal letters, then letter 5 column 0
        run_to_draw("r034_reach_draw", 1'b0);
        cycle(1'b1, 8'h1F, 1'b0);
        cycle(1'b1, 8'h3A, 1'b0);
        cycle(1'b1, 8'h05, 1'b0);
        #1;
        check_eq("r034_rejects", reject_count, 2);
        check_eq("r034_valid", spawn_valid, 1);
        check_eq("r034_letter", spawn_letter, 5);
        check_eq("r034_column", spawn_column, 0);

        // Repeat of letter 7 is rejected, then letter 8 column 2 accepted
        run_to_draw("r035_reach_draw1", 1'b1);
        cycle(1'b1, 8'h07, 1'b1);
        run_to_draw("r035_reach_draw2", 1'b1);
        cycle(1'b1, 8'h27, 1'b1);
        #1;
        check_eq("r035_repeat_rejected", reject_count, 3);
        cycle(1'b1, 8'h48, 1'b1);
        #1;
        check_eq("r035_valid", spawn_valid, 1);
        check_eq("r035_letter", spawn_letter, 8);
        check_eq("r035_column", spawn_column, 2);

        // Push spacing with no backpressure and all draws accepted
        rises.delete();
        for (int i = 0; i < 8 * (PERIOD + 1); i++) cycle(1'b1, pick_ok(), 1'b1);
        check_eq("r036_enough_pushes", rises.size() >= 4, 1);
        for (int i = 1; i < rises.size(); i++)
            check_eq("r036_spacing", rises[i] - rises[i-1], PERIOD + 1);

        // Fill the queue, reach HOLD, then one pop lets the candidate in
        n = 0;
        while (!(m_hold && mq.size() == DEPTH) && n < 200) begin
            cycle(1'b1, pick_ok(), 1'b0);
            n++;
        end
        check_eq("r037_reach_hold", m_hold, 1);
        #1;
        check_eq("r037_pending_full", pending, DEPTH);
        cycle(1'b1, pick_ok(), 1'b1);
        #1;
        check_eq("r037_pending_kept", pending, DEPTH);
        check_eq("r037_hold_left", m_hold, 0);
        for (int i = 0; i < 6; i++) cycle(1'b1, pick_ok(), 1'b0);

        // Drain, then queue 3 and drop enable while drawing
        n = 0;
        while (mq.size() != 0 && n < 50) begin
            cycle(1'b0, 8'($urandom), 1'b1);
            n++;
        end
        n = 0;
        while (!(mq.size() == 3 && model_drawing()) && n < 200) begin
            cycle(1'b1, pick_ok(), 1'b0);
            n++;
        end
        check_eq("r038_setup", mq.size() == 3 && model_drawing(), 1);
        cycle(1'b0, pick_ok(), 1'b1);
        #1;
        check_eq("r038_pending_2", pending, 2);
        cycle(1'b0, pick_ok(), 1'b1);
        #1;
        check_eq("r038_pending_1", pending, 1);
        cycle(1'b0, pick_ok(), 1'b1);
        #1;
        check_eq("r038_pending_0", pending, 0);
        for (int i = 0; i < 2 * PERIOD + 4; i++) cycle(1'b0, pick_ok(), 1'b1);

        // Asynchronous reset mid-WAIT with two entries queued
        n = 0;
        while (!(mq.size() == 2 && m_active && !m_hold && m_wait > 0 && m_wait < PERIOD) && n < 200) begin
            cycle(1'b1, pick_ok(), 1'b0);
            n++;
        end
        #1;
        check_eq("r033_pre_pending", pending, 2);
        do_reset("r033");
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'($urandom), 1'b1);

        // Reject counter saturation
        for (int i = 0; i < 300 + PERIOD; i++) cycle(1'b1, 8'hFF, 1'b1);
        #1;
        check_eq("reject_saturated", reject_count, 255);

        // Random traffic
        do_reset("rnd_start");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset("rnd_reset");
            cycle($urandom_range(0, 19) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
